// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//   Memory-side responder for the processor's data load/store interface.
//   Accepts one word request at a time and serves it as four single-byte
//   accesses to a byte-wide array. Words are big-endian: byte addr+0 holds
//   bits [31:24]. Results come back on a valid/ready response channel.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  request present
//   req_ready  responder can accept a request (IDLE only)
//   req_we     1 = store word, 0 = load word
//   req_addr   byte address; bits above ADDR_W are ignored (aliasing)
//   req_wdata  store data
//   rsp_valid  response present
//   rsp_ready  initiator accepts the response
//   rsp_rdata  load data; 0 for stores and misaligned requests
//   rsp_err    misaligned request, no memory access was made
// -----------------------------------------------------------------------------
module data_mem_responder #(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_RESP
   } state_e;

   state_e            state_q;
   logic [1:0]        cnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q;
   logic              err_q;
   logic              req_ready_q;
   logic              rsp_valid_q;

   logic [7:0]        mem_q [DEPTH];

   logic [ADDR_W-1:0] idx;
   logic [7:0]        rd_byte;
   logic [7:0]        wr_byte;
   logic [31:0]       rdata_d;

   // Address bits above the array index only alias; they are deliberately dropped.
   logic unused_addr_bits;
   assign unused_addr_bits = ^req_addr[31:ADDR_W];

   // Byte index wraps naturally modulo DEPTH through the ADDR_W-bit add.
   assign idx     = addr_q + ADDR_W'(cnt_q);
   assign rd_byte = mem_q[idx];

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      wr_byte = wdata_q[31:24];
      rdata_d = rdata_q;
      case (cnt_q)
         2'd0: begin wr_byte = wdata_q[31:24]; rdata_d[31:24] = rd_byte; end
         2'd1: begin wr_byte = wdata_q[23:16]; rdata_d[23:16] = rd_byte; end
         2'd2: begin wr_byte = wdata_q[15:8];  rdata_d[15:8]  = rd_byte; end
         default: begin wr_byte = wdata_q[7:0]; rdata_d[7:0]  = rd_byte; end
      endcase
   end

   // NOTE: the data array has no reset; its contents must survive rst_n.
   // A reset mid-store forces state_q to IDLE, which stops further writes.
   always_ff @(posedge clk) begin
      if (state_q == S_ACCESS && we_q) begin
         mem_q[idx] <= wr_byte;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= 2'd0;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= 32'h0;
         rdata_q     <= 32'h0;
         err_q       <= 1'b0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid && req_ready_q) begin
                  // Latched copies drive the whole access; req_* is ignored until IDLE.
                  addr_q      <= req_addr[ADDR_W-1:0];
                  we_q        <= req_we;
                  wdata_q     <= req_wdata;
                  rdata_q     <= 32'h0;
                  cnt_q       <= 2'd0;
                  req_ready_q <= 1'b0;
                  if (req_addr[1:0] != 2'b00) begin
                     err_q       <= 1'b1;
                     rsp_valid_q <= 1'b1;
                     state_q     <= S_RESP;
                  end else begin
                     err_q   <= 1'b0;
                     state_q <= S_ACCESS;
                  end
               end
            end
            S_ACCESS: begin
               if (!we_q) begin
                  rdata_q <= rdata_d;
               end
               cnt_q <= cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  rsp_valid_q <= 1'b1;
                  state_q     <= S_RESP;
               end
            end
            S_RESP: begin
               // Response registers hold until consumed; no new request here.
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//   Directed bench for data_mem_responder. Inputs change on the falling edge,
//   outputs are sampled on the falling edge; expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int n_total;
   int n_bad;

   data_mem_responder #(.DEPTH(32), .ADDR_W(5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Present a request at a falling edge, wait (bounded) for req_ready, let the
   // handshake edge pass (cycle N). Returns at the falling edge of cycle N+1.
   task automatic issue(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata);
      int k;
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      k = 0;
      while (!req_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!req_ready) check({tag, "_accept_timeout"}, 32'(req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Count cycles from N+1 until rsp_valid; also note whether req_ready rose meanwhile.
   task automatic wait_rsp(output int lat, output logic rdy_hi);
      lat    = 1;
      rdy_hi = req_ready;
      while (!rsp_valid && lat < 30) begin
         @(negedge clk);
         lat++;
         rdy_hi = rdy_hi | req_ready;
      end
   endtask

   // Accept the response now showing; check the channel returns to IDLE next cycle.
   task automatic take_rsp(input string tag);
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      check({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
      check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
   endtask

   task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input logic exp_err, input int exp_lat);
      int   lat;
      logic rdy_hi;
      issue(tag, we, addr, wdata);
      wait_rsp(lat, rdy_hi);
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_rdy_busy"}, 32'(rdy_hi), 32'd0);
      check({tag, "_rdata"}, rsp_rdata, exp_rdata);
      check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
      take_rsp(tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          lat;
      logic        rdy_hi;
      logic [31:0] held;

      n_total   = 0;
      n_bad     = 0;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = 32'h0;
      req_wdata = 32'h0;
      rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rdata", rsp_rdata, 32'h0);
      check("rst_err", 32'(rsp_err), 32'd0);
      rst_n = 1'b1;

      // 1: store then load the same word.
      txn("t1_st", 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0, 1'b0, 5);
      txn("t1_ld", 1'b0, 32'h0000_0008, 32'h0, 32'hDEAD_BEEF, 1'b0, 5);

      // 2: aligned load latency; a conflicting store is held on req_* while busy
      //    and must be ignored.
      issue("t2", 1'b0, 32'h0000_0008, 32'h0);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'h0000_0008;
      req_wdata = 32'h0000_0000;
      wait_rsp(lat, rdy_hi);
      req_valid = 1'b0;
      check("t2_lat", 32'(lat), 32'd5);
      check("t2_rdy_busy", 32'(rdy_hi), 32'd0);
      check("t2_rdata", rsp_rdata, 32'hDEAD_BEEF);
      take_rsp("t2");
      txn("t2_reld", 1'b0, 32'h0000_0008, 32'h0, 32'hDEAD_BEEF, 1'b0, 5);

      // 3: misaligned load and store report an error after one cycle, no access.
      txn("t3_ld", 1'b0, 32'h0000_0005, 32'h0, 32'h0, 1'b1, 1);
      txn("t3_st", 1'b1, 32'h0000_0009, 32'h1234_5678, 32'h0, 1'b1, 1);
      txn("t3_chk", 1'b0, 32'h0000_0008, 32'h0, 32'hDEAD_BEEF, 1'b0, 5);

      // 4: high address aliases modulo DEPTH (0x3C -> index 28).
      txn("t4_st", 1'b1, 32'h0000_003C, 32'h1122_3344, 32'h0, 1'b0, 5);
      txn("t4_ld", 1'b0, 32'h0000_001C, 32'h0, 32'h1122_3344, 1'b0, 5);
      txn("t4_hi", 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h1122_3344, 1'b0, 5);

      // 5: backpressure holds the response stable.
      issue("t5", 1'b0, 32'h0000_001C, 32'h0);
      wait_rsp(lat, rdy_hi);
      check("t5_lat", 32'(lat), 32'd5);
      held = rsp_rdata;
      check("t5_rdata", held, 32'h1122_3344);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("t5_hold_valid%0d", i), 32'(rsp_valid), 32'd1);
         check($sformatf("t5_hold_rdata%0d", i), rsp_rdata, 32'h1122_3344);
         check($sformatf("t5_hold_ready%0d", i), 32'(req_ready), 32'd0);
      end
      take_rsp("t5");

      // 6: reset after two bytes of a store leaves a half-written word.
      txn("t6_fill", 1'b1, 32'h0000_0010, 32'hAAAA_AAAA, 32'h0, 1'b0, 5);
      issue("t6_st", 1'b1, 32'h0000_0010, 32'h0102_0304);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", 32'(rsp_valid), 32'd0);
      check("t6_rst_ready", 32'(req_ready), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rdy_hi = 1'b1;
      lat    = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         rdy_hi = rdy_hi & req_ready;
         lat    = lat + int'(rsp_valid);
      end
      check("t6_post_ready", 32'(rdy_hi), 32'd1);
      check("t6_post_valid", 32'(lat), 32'd0);
      txn("t6_ld", 1'b0, 32'h0000_0010, 32'h0, 32'h0102_AAAA, 1'b0, 5);
      txn("t6_keep", 1'b0, 32'h0000_0008, 32'h0, 32'hDEAD_BEEF, 1'b0, 5);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
